// File: rtl/async_fifo_rd_pkg.sv
// Shared types and helpers for the async FIFO read-side drain engine.
// occ_t is sized for the largest supported output buffer (4 entries).
package async_fifo_rd_pkg;

   localparam int DSIZE_DEF = 8;
   localparam int CNT_W_DEF = 16;
   localparam int OCC_W     = 3;

   typedef logic [OCC_W-1:0] occ_t;

   // A new pop may issue only if every word already owned (buffered or in flight),
   // less the one leaving this cycle, still leaves a free slot.
   function automatic logic slot_free(input occ_t occ, input logic infl,
                                      input logic xfer, input occ_t depth);
      logic [OCC_W:0] owned;
      logic [OCC_W:0] limit;
      owned = {1'b0, occ} + {{OCC_W{1'b0}}, infl};
      limit = {1'b0, depth} + {{OCC_W{1'b0}}, xfer};
      return (owned < limit);
   endfunction

endpackage

// File: rtl/async_fifo_rd_skidbuf.sv
// Small circular output buffer; occupancy doubles as the buffer state
// (EMPTY, ONE, ... FULL), head entry is presented combinationally.
module async_fifo_rd_skidbuf
   import async_fifo_rd_pkg::*;
#(
   parameter int DSIZE     = DSIZE_DEF,
   parameter int BUF_DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [DSIZE-1:0] push_data_i,
   input  logic             pop_i,
   output logic [DSIZE-1:0] head_o,
   output occ_t             occ_o
);

   logic [DSIZE-1:0] mem_q [0:3];
   logic [1:0]       wr_ptr_q;
   logic [1:0]       rd_ptr_q;
   occ_t             occ_q;

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   // Storage, pointers and occupancy; push and pop on the same edge keep occupancy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 4; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         occ_q    <= occ_t'(0);
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= next_ptr(wr_ptr_q);
         end
         if (pop_i) begin
            rd_ptr_q <= next_ptr(rd_ptr_q);
         end
         case ({push_i, pop_i})
            2'b10:   occ_q <= occ_q + occ_t'(1);
            2'b01:   occ_q <= occ_q - occ_t'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign head_o = mem_q[rd_ptr_q];
   assign occ_o  = occ_q;

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-side drain engine: pops the async FIFO in the rclk domain and streams
// words out through a small buffer as valid/ready, counting delivered words.
module async_fifo_rd_stream
   import async_fifo_rd_pkg::*;
#(
   parameter int DSIZE     = DSIZE_DEF,
   parameter int RD_LAT    = 0,
   parameter int BUF_DEPTH = 2,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                           rclk,
   input  logic                           rrst_n,
   input  logic                           rd_en,
   input  logic                           rempty,
   input  logic [DSIZE-1:0]               rdata,
   output logic                           rinc,
   output logic [DSIZE-1:0]               m_data,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [$clog2(BUF_DEPTH+1)-1:0] occ,
   output logic [CNT_W-1:0]               pop_cnt
);

   localparam int OCC_OUT_W = $clog2(BUF_DEPTH + 1);

   logic             run_q;
   logic             infl_q;
   logic             infl_d;
   logic [CNT_W-1:0] pop_cnt_q;
   logic [CNT_W-1:0] pop_cnt_d;
   occ_t             buf_occ_s;
   logic             xfer_s;
   logic             rinc_s;
   logic             cap_s;

   assign m_valid = (buf_occ_s != occ_t'(0));
   assign xfer_s  = m_valid && m_ready;

   // run_q holds off pops for the first edge after reset release.
   assign rinc_s = run_q && rd_en && !rempty &&
                   slot_free(buf_occ_s, infl_q, xfer_s, occ_t'(BUF_DEPTH));
   assign cap_s  = (RD_LAT == 0) ? rinc_s : infl_q;

   // Next-state for the in-flight flag and the delivered-word counter.
   always_comb begin
      infl_d    = (RD_LAT == 1) && rinc_s;
      pop_cnt_d = pop_cnt_q;
      if (xfer_s) begin
         pop_cnt_d = pop_cnt_q + CNT_W'(1);
      end else begin
         pop_cnt_d = pop_cnt_q;
      end
   end

   // Control registers; reset discards any word still in flight.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         run_q     <= 1'b0;
         infl_q    <= 1'b0;
         pop_cnt_q <= '0;
      end else begin
         run_q     <= 1'b1;
         infl_q    <= infl_d;
         pop_cnt_q <= pop_cnt_d;
      end
   end

   async_fifo_rd_skidbuf #(
      .DSIZE     (DSIZE),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk_i       (rclk),
      .rst_ni      (rrst_n),
      .push_i      (cap_s),
      .push_data_i (rdata),
      .pop_i       (xfer_s),
      .head_o      (m_data),
      .occ_o       (buf_occ_s)
   );

   assign rinc    = rinc_s;
   assign occ     = buf_occ_s[OCC_OUT_W-1:0];
   assign pop_cnt = pop_cnt_q;

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Directed bench: instance A is fall-through (RD_LAT=0), instance B has
// RD_LAT=1 and a 2-bit counter; each reads a simple behavioural FIFO model.
module tb_async_fifo_rd_stream;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rd_en_a, m_ready_a, rinc_a, m_valid_a, rempty_a;
   logic [7:0] rdata_a, m_data_a;
   logic [1:0] occ_a;
   logic [15:0] pop_cnt_a;
   logic       rd_en_b, m_ready_b, rinc_b, m_valid_b, rempty_b;
   logic [7:0] rdata_b, m_data_b;
   logic [1:0] occ_b;
   logic [1:0] pop_cnt_b;

   int nvec = 0;
   int nerr = 0;
   int viol = 0;

   logic [7:0] mem_a [0:255];
   logic [7:0] mem_b [0:255];
   logic [7:0] wa = 8'd0, ra = 8'd0, wb = 8'd0, rb = 8'd0;
   logic [7:0] exp_b [$];

   always #5 clk = ~clk;

   async_fifo_rd_stream #(.DSIZE(8), .RD_LAT(0), .BUF_DEPTH(2), .CNT_W(16)) dut_a (
      .rclk(clk), .rrst_n(rst_n), .rd_en(rd_en_a), .rempty(rempty_a), .rdata(rdata_a),
      .rinc(rinc_a), .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
      .occ(occ_a), .pop_cnt(pop_cnt_a));

   async_fifo_rd_stream #(.DSIZE(8), .RD_LAT(1), .BUF_DEPTH(2), .CNT_W(2)) dut_b (
      .rclk(clk), .rrst_n(rst_n), .rd_en(rd_en_b), .rempty(rempty_b), .rdata(rdata_b),
      .rinc(rinc_b), .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
      .occ(occ_b), .pop_cnt(pop_cnt_b));

   // FIFO models: A is fall-through, B returns data the cycle after rinc.
   assign rempty_a = (wa == ra);
   assign rdata_a  = mem_a[ra];
   assign rempty_b = (wb == rb);

   always @(posedge clk) begin
      if (rinc_a) ra <= ra + 8'd1;
      if (rinc_b) begin
         rdata_b <= mem_b[rb];
         rb      <= rb + 8'd1;
      end
   end

   always @(negedge clk) begin
      a_no_pop_empty: assert (!((rinc_a && rempty_a) || (rinc_b && rempty_b))) else begin
         viol++;
         $display("FAIL rinc_while_empty: rinc_a=%0b rinc_b=%0b required 0 while rempty", rinc_a, rinc_b);
      end
   end

   typedef struct {
      logic        rd_en;
      logic        rdy;
      logic        exp_valid;
      logic [7:0]  exp_data;
      logic [1:0]  exp_occ;
      logic        exp_rinc;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t tv [15];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_a(input logic [7:0] d);
      mem_a[wa] = d;
      wa = wa + 8'd1;
   endtask

   task automatic push_b(input logic [7:0] d);
      mem_b[wb] = d;
      wb = wb + 8'd1;
      exp_b.push_back(d);
   endtask

   // Drains nwords from B, checking order, occupancy bound and pop_cnt after each transfer.
   task automatic drain_b(input int nwords, input bit toggle, input logic [1:0] cnt_base);
      int got = 0;
      logic [7:0] w;
      logic [1:0] ecnt;
      rd_en_b = 1'b1;
      for (int cyc = 0; cyc < 60 && got < nwords; cyc++) begin
         @(negedge clk);
         m_ready_b = toggle ? ((cyc % 2) == 0) : 1'b1;
         #1;
         chk("occ_b_bound", {15'd0, (occ_b > 2'd2)}, 16'd0);
         if (m_valid_b && m_ready_b) begin
            w = (exp_b.size() > 0) ? exp_b.pop_front() : 8'hxx;
            chk("stream_b_data", {8'd0, m_data_b}, {8'd0, w});
            got++;
            @(posedge clk);
            #1;
            ecnt = cnt_base + 2'(got);
            chk("pop_cnt_b", {14'd0, pop_cnt_b}, {14'd0, ecnt});
         end
      end
      chk("drain_b_words", 16'(got), 16'(nwords));
      @(negedge clk);
      m_ready_b = 1'b0;
   endtask

   initial begin
      tv[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 16'd0};
      tv[1]  = '{1'b1, 1'b1, 1'b1, 8'h11, 2'd1, 1'b1, 16'd0};
      tv[2]  = '{1'b1, 1'b1, 1'b1, 8'h22, 2'd1, 1'b1, 16'd1};
      tv[3]  = '{1'b1, 1'b1, 1'b1, 8'h33, 2'd1, 1'b0, 16'd2};
      tv[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 16'd3};
      tv[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 16'd3};
      tv[6]  = '{1'b1, 1'b0, 1'b1, 8'hA1, 2'd1, 1'b1, 16'd3};
      tv[7]  = '{1'b1, 1'b0, 1'b1, 8'hA1, 2'd2, 1'b0, 16'd3};
      tv[8]  = '{1'b1, 1'b0, 1'b1, 8'hA1, 2'd2, 1'b0, 16'd3};
      tv[9]  = '{1'b1, 1'b1, 1'b1, 8'hA1, 2'd2, 1'b1, 16'd3};
      tv[10] = '{1'b1, 1'b1, 1'b1, 8'hA2, 2'd2, 1'b1, 16'd4};
      tv[11] = '{1'b1, 1'b1, 1'b1, 8'hA3, 2'd2, 1'b1, 16'd5};
      tv[12] = '{1'b1, 1'b1, 1'b1, 8'hA4, 2'd2, 1'b0, 16'd6};
      tv[13] = '{1'b1, 1'b1, 1'b1, 8'hA5, 2'd1, 1'b0, 16'd7};
      tv[14] = '{1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 16'd8};

      rst_n = 1'b0;
      rd_en_a = 1'b0; m_ready_a = 1'b0; rd_en_b = 1'b0; m_ready_b = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_occ_a", {14'd0, occ_a}, 16'd0);
      chk("reset_valid_a", {15'd0, m_valid_a}, 16'd0);
      chk("reset_data_a", {8'd0, m_data_a}, 16'd0);
      chk("reset_cnt_a", pop_cnt_a, 16'd0);
      chk("reset_cnt_b", {14'd0, pop_cnt_b}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Tests 1 and 2 on the fall-through instance, one row per cycle.
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (i == 0) begin
            push_a(8'h11); push_a(8'h22); push_a(8'h33);
         end
         if (i == 5) begin
            for (int k = 1; k <= 5; k++) push_a(8'hA0 + 8'(k));
         end
         rd_en_a   = tv[i].rd_en;
         m_ready_a = tv[i].rdy;
         #1;
         chk($sformatf("row%0d_valid", i), {15'd0, m_valid_a}, {15'd0, tv[i].exp_valid});
         if (tv[i].exp_valid) chk($sformatf("row%0d_data", i), {8'd0, m_data_a}, {8'd0, tv[i].exp_data});
         chk($sformatf("row%0d_occ", i), {14'd0, occ_a}, {14'd0, tv[i].exp_occ});
         chk($sformatf("row%0d_rinc", i), {15'd0, rinc_a}, {15'd0, tv[i].exp_rinc});
         chk($sformatf("row%0d_cnt", i), pop_cnt_a, tv[i].exp_cnt);
      end

      // Test 5 then test 3 on the RD_LAT=1 instance with 2-bit counter.
      @(negedge clk);
      for (int k = 1; k <= 4; k++) push_b(8'h50 + 8'(k));
      drain_b(4, 1'b0, 2'd0);
      @(negedge clk);
      for (int k = 0; k < 8; k++) push_b(8'h30 + 8'(k));
      drain_b(8, 1'b1, 2'd0);

      // Test 4: drop rd_en with one word in flight.
      @(negedge clk);
      rd_en_b = 1'b0;
      exp_b.delete();
      push_b(8'hC1); push_b(8'hC2); push_b(8'hC3);
      @(negedge clk);
      rd_en_b = 1'b1; m_ready_b = 1'b1;
      #1;
      chk("t4_first_rinc", {15'd0, rinc_b}, 16'd1);
      @(negedge clk);
      rd_en_b = 1'b0;
      #1;
      chk("t4_rinc_off", {15'd0, rinc_b}, 16'd0);
      chk("t4_not_yet_valid", {15'd0, m_valid_b}, 16'd0);
      @(negedge clk);
      #1;
      chk("t4_valid", {15'd0, m_valid_b}, 16'd1);
      chk("t4_data", {8'd0, m_data_b}, 16'h00C1);
      chk("t4_rinc_idle", {15'd0, rinc_b}, 16'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk("t4_drained", {15'd0, m_valid_b}, 16'd0);
         chk("t4_no_rinc", {15'd0, rinc_b}, 16'd0);
      end

      // Test 6: async reset with the fall-through buffer full.
      @(negedge clk);
      push_a(8'hD1); push_a(8'hD2); push_a(8'hD3);
      rd_en_a = 1'b1; m_ready_a = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("t6_full", {14'd0, occ_a}, 16'd2);
      rst_n = 1'b0;
      #1;
      chk("t6_valid_async", {15'd0, m_valid_a}, 16'd0);
      chk("t6_occ_async", {14'd0, occ_a}, 16'd0);
      chk("t6_rinc_in_reset", {15'd0, rinc_a}, 16'd0);
      @(negedge clk);
      #1;
      chk("t6_rinc_held", {15'd0, rinc_a}, 16'd0);
      rst_n = 1'b1;
      #1;
      chk("t6_rinc_first_edge", {15'd0, rinc_a}, 16'd0);
      chk("t6_cnt_cleared", pop_cnt_a, 16'd0);
      @(negedge clk);
      #1;
      chk("t6_rinc_resumes", {15'd0, rinc_a}, 16'd1);

      @(negedge clk);
      rd_en_a = 1'b0; rd_en_b = 1'b0;
      chk("no_rinc_while_empty", 16'(viol), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
